// File: rtl/minisrc_pkg.sv
// Shared Mini SRC control definitions: sequencer states, branch condition codes,
// opcode/ALU constants and the per-state control strobe decode.
package minisrc_pkg;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, DONE
  } state_t;

  typedef enum logic [1:0] {
    C2_ZR = 2'b00,
    C2_NZ = 2'b01,
    C2_PL = 2'b10,
    C2_MI = 2'b11
  } c2_t;

  localparam logic [4:0] MINISRC_BR_OPCODE = 5'b10010;
  localparam logic [4:0] MINISRC_ALU_ADD   = 5'b00011;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pc_out;
    logic       mar_in;
    logic       inc_pc;
    logic       z_in;
    logic       zlow_out;
    logic       pc_in;
    logic       read;
    logic       mdr_in;
    logic       mdr_out;
    logic       ir_in;
    logic       grb;
    logic       rout;
    logic       y_in;
    logic       c_out;
    logic [4:0] alu;
  } ctrl_t;

  // Strobes for a given state; con only matters for the T6 PC write-back.
  function automatic ctrl_t ctrl_for(state_t s, logic con, logic [4:0] alu_add);
    ctrl_t c;
    c = '0;
    c.busy = (s != IDLE);
    case (s)
      T0: begin
        c.pc_out = 1'b1;
        c.mar_in = 1'b1;
        c.inc_pc = 1'b1;
        c.z_in   = 1'b1;
      end
      T1: begin
        c.zlow_out = 1'b1;
        c.pc_in    = 1'b1;
        c.read     = 1'b1;
        c.mdr_in   = 1'b1;
      end
      T2: begin
        c.mdr_out = 1'b1;
        c.ir_in   = 1'b1;
      end
      T3: begin
        c.grb  = 1'b1;
        c.rout = 1'b1;
      end
      T4: begin
        c.pc_out = 1'b1;
        c.y_in   = 1'b1;
      end
      T5: begin
        c.c_out = 1'b1;
        c.z_in  = 1'b1;
        c.alu   = alu_add;
      end
      T6: begin
        c.zlow_out = 1'b1;
        c.pc_in    = con;
      end
      DONE:    c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// Handshake, datapath bus and control strobes between the sequencer and its user.
interface branch_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  // The instruction format is fixed at 32 bits regardless of the datapath width.
  logic                  start;
  logic [31:0]           IR_Data;
  logic [DATA_WIDTH-1:0] Bus_Data;

  logic busy, done, taken, illegal;
  logic PC_out, MAR_in, IncPC, Z_in, Zlow_out, PC_in, Read;
  logic MDR_in, MDR_out, IR_in, Grb, Rout, Y_in, C_out;
  logic [4:0] alu_instruction_bits;

  modport master (
    output start, IR_Data, Bus_Data,
    input  busy, done, taken, illegal,
    input  PC_out, MAR_in, IncPC, Z_in, Zlow_out, PC_in, Read,
    input  MDR_in, MDR_out, IR_in, Grb, Rout, Y_in, C_out,
    input  alu_instruction_bits
  );

  modport slave (
    input  start, IR_Data, Bus_Data,
    output busy, done, taken, illegal,
    output PC_out, MAR_in, IncPC, Z_in, Zlow_out, PC_in, Read,
    output MDR_in, MDR_out, IR_in, Grb, Rout, Y_in, C_out,
    output alu_instruction_bits
  );
endinterface

// File: rtl/branch_sequencer_con_ff_logic.sv
// Branch condition evaluation on the bus value and the CON flip-flop that holds it.
module con_ff_logic
  import minisrc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  en,
  input  c2_t                   c2,
  input  logic [DATA_WIDTH-1:0] value,
  output logic                  cond,
  output logic                  con_q
);

  logic is_zero;
  logic is_neg;

  assign is_zero = (value == '0);
  assign is_neg  = value[DATA_WIDTH-1];

  always_comb begin
    cond = 1'b0;
    case (c2)
      C2_ZR:   cond = is_zero;
      C2_NZ:   cond = !is_zero;
      C2_PL:   cond = !is_neg;
      C2_MI:   cond = is_neg;
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      con_q <= 1'b0;
    end else if (en) begin
      con_q <= cond;
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Fetch-to-PC-update sequencer for one Mini SRC conditional branch (brzr/brnz/brpl/brmi).
module branch_sequencer
  import minisrc_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter logic [4:0] BR_OPCODE  = MINISRC_BR_OPCODE,
  parameter logic [4:0] ALU_ADD    = MINISRC_ALU_ADD,
  parameter bit         EARLY_EXIT = 1'b1
) (
  input logic         clk,
  input logic         clr,
  branch_sequencer_if.slave sif
);

  state_t state_reg, state_next;
  ctrl_t  ctrl_reg;
  logic   taken_reg, illegal_reg;
  logic   opcode_ok, capture, cond_now, con_q, con_next;
  logic   unused_ir;

  assign opcode_ok = (sif.IR_Data[31:27] == BR_OPCODE);
  assign capture   = (state_reg == T3) && opcode_ok;
  assign con_next  = capture ? cond_now : con_q;
  assign unused_ir = ^{sif.IR_Data[26:21], sif.IR_Data[18:0]};

  con_ff_logic #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_con (
    .clk   (clk),
    .clr   (clr),
    .en    (capture),
    .c2    (c2_t'(sif.IR_Data[20:19])),
    .value (sif.Bus_Data),
    .cond  (cond_now),
    .con_q (con_q)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (sif.start) state_next = T0;
      T0:   state_next = T1;
      T1:   state_next = T2;
      T2:   state_next = T3;
      T3: begin
        if (!opcode_ok)                    state_next = DONE;
        else if (cond_now || !EARLY_EXIT)  state_next = T4;
        else                               state_next = DONE;
      end
      T4:      state_next = T5;
      T5:      state_next = T6;
      T6:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they appear registered in the state they belong to.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg   <= IDLE;
      ctrl_reg    <= '0;
      taken_reg   <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= ctrl_for(state_next, con_next, ALU_ADD);
      if (state_reg == T3) begin
        illegal_reg <= !opcode_ok;
      end
      if (state_next == DONE) begin
        taken_reg <= (state_reg == T3) ? (opcode_ok && cond_now) : con_q;
      end
    end
  end

  assign sif.busy                 = ctrl_reg.busy;
  assign sif.done                 = ctrl_reg.done;
  assign sif.taken                = taken_reg;
  assign sif.illegal              = illegal_reg;
  assign sif.PC_out               = ctrl_reg.pc_out;
  assign sif.MAR_in               = ctrl_reg.mar_in;
  assign sif.IncPC                = ctrl_reg.inc_pc;
  assign sif.Z_in                 = ctrl_reg.z_in;
  assign sif.Zlow_out             = ctrl_reg.zlow_out;
  assign sif.PC_in                = ctrl_reg.pc_in;
  assign sif.Read                 = ctrl_reg.read;
  assign sif.MDR_in               = ctrl_reg.mdr_in;
  assign sif.MDR_out              = ctrl_reg.mdr_out;
  assign sif.IR_in                = ctrl_reg.ir_in;
  assign sif.Grb                  = ctrl_reg.grb;
  assign sif.Rout                 = ctrl_reg.rout;
  assign sif.Y_in                 = ctrl_reg.y_in;
  assign sif.C_out                = ctrl_reg.c_out;
  assign sif.alu_instruction_bits = ctrl_reg.alu;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench: three sequencer instances (32b full path, 32b early exit, 16b early exit) run in lockstep.
module tb_branch_sequencer;

  localparam int B_BUSY = 20, B_DONE = 19, B_PCOUT = 18, B_MARIN = 17, B_INCPC = 16;
  localparam int B_ZIN = 15, B_ZLOW = 14, B_PCIN = 13, B_READ = 12, B_MDRIN = 11;
  localparam int B_MDROUT = 10, B_IRIN = 9, B_GRB = 8, B_ROUT = 7, B_YIN = 6, B_COUT = 5;
  localparam logic [4:0] OPC_BR = 5'b10010;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic [31:0] ir = '0;
  logic [31:0] bus0 = '0, bus1 = '0;
  logic [15:0] bus2 = '0;
  int          total = 0;
  int          bad = 0;

  logic [20:0] obs_tr [3][11];
  logic [20:0] exp_tr [3][11];
  logic        obs_taken [3], obs_ill [3], exp_taken [3], exp_ill [3];
  logic [20:0] v [3];
  logic        tk [3], il [3];

  always #5 clk = ~clk;

  branch_sequencer_if #(.DATA_WIDTH(32)) i0 ();
  branch_sequencer_if #(.DATA_WIDTH(32)) i1 ();
  branch_sequencer_if #(.DATA_WIDTH(16)) i2 ();

  branch_sequencer #(.DATA_WIDTH(32), .EARLY_EXIT(1'b0)) dut0 (.clk(clk), .clr(clr), .sif(i0));
  branch_sequencer #(.DATA_WIDTH(32), .EARLY_EXIT(1'b1)) dut1 (.clk(clk), .clr(clr), .sif(i1));
  branch_sequencer #(.DATA_WIDTH(16), .EARLY_EXIT(1'b1)) dut2 (.clk(clk), .clr(clr), .sif(i2));

  assign i0.start = start;  assign i0.IR_Data = ir;  assign i0.Bus_Data = bus0;
  assign i1.start = start;  assign i1.IR_Data = ir;  assign i1.Bus_Data = bus1;
  assign i2.start = start;  assign i2.IR_Data = ir;  assign i2.Bus_Data = bus2;

  assign v[0] = {i0.busy, i0.done, i0.PC_out, i0.MAR_in, i0.IncPC, i0.Z_in, i0.Zlow_out, i0.PC_in,
                 i0.Read, i0.MDR_in, i0.MDR_out, i0.IR_in, i0.Grb, i0.Rout, i0.Y_in, i0.C_out,
                 i0.alu_instruction_bits};
  assign v[1] = {i1.busy, i1.done, i1.PC_out, i1.MAR_in, i1.IncPC, i1.Z_in, i1.Zlow_out, i1.PC_in,
                 i1.Read, i1.MDR_in, i1.MDR_out, i1.IR_in, i1.Grb, i1.Rout, i1.Y_in, i1.C_out,
                 i1.alu_instruction_bits};
  assign v[2] = {i2.busy, i2.done, i2.PC_out, i2.MAR_in, i2.IncPC, i2.Z_in, i2.Zlow_out, i2.PC_in,
                 i2.Read, i2.MDR_in, i2.MDR_out, i2.IR_in, i2.Grb, i2.Rout, i2.Y_in, i2.C_out,
                 i2.alu_instruction_bits};
  assign tk[0] = i0.taken;  assign tk[1] = i1.taken;  assign tk[2] = i2.taken;
  assign il[0] = i0.illegal; assign il[1] = i1.illegal; assign il[2] = i2.illegal;

  // Condition straight from the rules: compare against zero or against half the range.
  function automatic bit ref_cond(logic [1:0] c2, longint unsigned val, int w);
    longint unsigned half = 64'd1 << (w - 1);
    case (c2)
      2'd0:    return val == 0;
      2'd1:    return val != 0;
      2'd2:    return val < half;
      default: return val >= half;
    endcase
  endfunction

  // Expected strobes for the t-th step of an instruction (t=7 is the completion cycle).
  function automatic logic [20:0] step_vec(int t, bit con);
    logic [20:0] s = '0;
    s[B_BUSY] = 1'b1;
    case (t)
      0: begin s[B_PCOUT] = 1; s[B_MARIN] = 1; s[B_INCPC] = 1; s[B_ZIN] = 1; end
      1: begin s[B_ZLOW] = 1; s[B_PCIN] = 1; s[B_READ] = 1; s[B_MDRIN] = 1; end
      2: begin s[B_MDROUT] = 1; s[B_IRIN] = 1; end
      3: begin s[B_GRB] = 1; s[B_ROUT] = 1; end
      4: begin s[B_PCOUT] = 1; s[B_YIN] = 1; end
      5: begin s[B_COUT] = 1; s[B_ZIN] = 1; s[4:0] = 5'b00011; end
      6: begin s[B_ZLOW] = 1; s[B_PCIN] = con; end
      default: s[B_DONE] = 1;
    endcase
    return s;
  endfunction

  // Launch one instruction on all three instances, record 10 cycles, build expectations.
  task automatic exec(input logic [31:0] ir_v, input logic [31:0] b0, input logic [31:0] b1,
                      input logic [15:0] b2);
    longint unsigned val;
    int w, n;
    bit ee, legal, cnd;
    @(negedge clk);
    ir = ir_v; bus0 = b0; bus1 = b1; bus2 = b2; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      for (int d = 0; d < 3; d++) obs_tr[d][k] = v[d];
    end
    for (int d = 0; d < 3; d++) begin
      obs_taken[d] = tk[d];
      obs_ill[d]   = il[d];
      w   = (d == 2) ? 16 : 32;
      ee  = (d != 0);
      val = (d == 0) ? longint'(b0) : (d == 1) ? longint'(b1) : longint'(b2);
      legal = (ir_v[31:27] == OPC_BR);
      cnd   = ref_cond(ir_v[20:19], val, w);
      n = (legal && (cnd || !ee)) ? 7 : 4;
      for (int k = 1; k <= 10; k++) begin
        if (k <= n)          exp_tr[d][k] = step_vec(k - 1, cnd);
        else if (k == n + 1) exp_tr[d][k] = step_vec(7, cnd);
        else                 exp_tr[d][k] = '0;
      end
      exp_taken[d] = legal && cnd;
      exp_ill[d]   = !legal;
    end
    $display("txn ir=%h bus0=%h bus1=%h bus2=%h taken=%0d%0d%0d illegal=%0d%0d%0d",
             ir_v, b0, b1, b2, obs_taken[0], obs_taken[1], obs_taken[2],
             obs_ill[0], obs_ill[1], obs_ill[2]);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (v[d] !== '0 || tk[d] !== 1'b0 || il[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset d%0d got ctrl=%h taken=%b illegal=%b expected all 0", d, v[d], tk[d], il[d]);
      end
    end
    clr = 1'b0;
  endtask

  // brmi on +2: not taken; full T0..T6 with PC_in low on the 32b/no-early-exit instance,
  // early finish on the other.
  task automatic test_not_taken();
    exec(32'h9018_0000, 32'h2, 32'h2, 16'h2);
    for (int d = 0; d < 2; d++) begin
      for (int k = 1; k <= 10; k++) begin
        total++;
        if (obs_tr[d][k] !== exp_tr[d][k]) begin
          bad++;
          $display("FAIL not_taken d%0d cycle%0d ctrl got=%h expected=%h", d, k, obs_tr[d][k], exp_tr[d][k]);
        end
      end
      total++;
      if (obs_taken[d] !== 1'b0 || obs_ill[d] !== 1'b0) begin
        bad++;
        $display("FAIL not_taken_flags d%0d taken=%b illegal=%b expected 0 0", d, obs_taken[d], obs_ill[d]);
      end
    end
  endtask

  task automatic test_taken_brzr();
    exec(32'h9000_0000, 32'h0, 32'h0, 16'h0);
    for (int d = 0; d < 3; d++) begin
      for (int k = 1; k <= 10; k++) begin
        total++;
        if (obs_tr[d][k] !== exp_tr[d][k]) begin
          bad++;
          $display("FAIL brzr d%0d cycle%0d ctrl got=%h expected=%h", d, k, obs_tr[d][k], exp_tr[d][k]);
        end
      end
      total++;
      if (obs_taken[d] !== 1'b1) begin
        bad++;
        $display("FAIL brzr_taken d%0d got=%b expected=1", d, obs_taken[d]);
      end
    end
    total++;
    if (obs_tr[0][6][4:0] !== 5'b00011) begin
      bad++;
      $display("FAIL brzr_alu T5 got=%b expected=00011", obs_tr[0][6][4:0]);
    end
  endtask

  // Same brmi on 0x8000: negative on the 16b instance, positive on the 32b one.
  task automatic test_width16();
    exec(32'h9018_0000, 32'h8000, 32'h8000, 16'h8000);
    for (int d = 1; d < 3; d++) begin
      for (int k = 1; k <= 10; k++) begin
        total++;
        if (obs_tr[d][k] !== exp_tr[d][k]) begin
          bad++;
          $display("FAIL width d%0d cycle%0d ctrl got=%h expected=%h", d, k, obs_tr[d][k], exp_tr[d][k]);
        end
      end
      total++;
      if (obs_taken[d] !== exp_taken[d]) begin
        bad++;
        $display("FAIL width_taken d%0d got=%b expected=%b", d, obs_taken[d], exp_taken[d]);
      end
    end
  endtask

  task automatic test_illegal();
    exec(32'h1800_0000, 32'h0, 32'h0, 16'h0);
    for (int d = 0; d < 3; d++) begin
      for (int k = 1; k <= 10; k++) begin
        total++;
        if (obs_tr[d][k] !== exp_tr[d][k]) begin
          bad++;
          $display("FAIL illegal d%0d cycle%0d ctrl got=%h expected=%h", d, k, obs_tr[d][k], exp_tr[d][k]);
        end
      end
      total++;
      if (obs_ill[d] !== 1'b1 || obs_taken[d] !== 1'b0) begin
        bad++;
        $display("FAIL illegal_flags d%0d illegal=%b taken=%b expected 1 0", d, obs_ill[d], obs_taken[d]);
      end
    end
  endtask

  // start held high: the next instruction begins one idle cycle after completion.
  task automatic test_back_to_back();
    logic [20:0] want;
    @(negedge clk);
    ir = 32'h1800_0000; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      want = (k <= 4) ? step_vec(k - 1, 1'b0) : (k == 5) ? step_vec(7, 1'b0) :
             (k == 6) ? 21'd0 : step_vec(k - 7, 1'b0);
      for (int d = 0; d < 3; d++) begin
        total++;
        if (v[d] !== want) begin
          bad++;
          $display("FAIL back_to_back d%0d cycle%0d ctrl got=%h expected=%h", d, k, v[d], want);
        end
      end
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // start pulsed in T2 must not queue; clr in T4 clears everything without a clock edge.
  task automatic test_clr_midway();
    @(negedge clk);
    ir = 32'h9000_0000; bus0 = '0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++;
    if (v[0] !== step_vec(3, 1'b0)) begin
      bad++;
      $display("FAIL clr_t3 ctrl got=%h expected=%h", v[0], step_vec(3, 1'b0));
    end
    @(negedge clk);
    total++;
    if (v[0] !== step_vec(4, 1'b0)) begin
      bad++;
      $display("FAIL clr_t4 ctrl got=%h expected=%h", v[0], step_vec(4, 1'b0));
    end
    #2 clr = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (v[d] !== '0 || tk[d] !== 1'b0 || il[d] !== 1'b0) begin
        bad++;
        $display("FAIL clr_async d%0d ctrl=%h taken=%b illegal=%b expected all 0", d, v[d], tk[d], il[d]);
      end
    end
    @(negedge clk); clr = 1'b0;
    repeat (4) begin
      @(negedge clk);
      total++;
      if (v[0] !== '0) begin
        bad++;
        $display("FAIL clr_idle ctrl got=%h expected=0", v[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r, rir, b0, b1;
    logic [15:0] b2;
    logic [4:0]  opc;
    for (int i = 0; i < 24; i++) begin
      r   = $urandom();
      opc = ($urandom_range(0, 3) != 0) ? OPC_BR : 5'($urandom());
      rir = {opc, r[26:0]};
      case ($urandom_range(0, 3))
        0: b0 = '0;
        1: b0 = 32'h8000_0000 | $urandom();
        2: b0 = $urandom() & 32'h7fff_ffff;
        default: b0 = $urandom();
      endcase
      b1 = ($urandom_range(0, 1) != 0) ? b0 : $urandom();
      case ($urandom_range(0, 3))
        0: b2 = '0;
        1: b2 = 16'h8000;
        2: b2 = 16'h7fff;
        default: b2 = 16'($urandom());
      endcase
      exec(rir, b0, b1, b2);
      for (int d = 0; d < 3; d++) begin
        for (int k = 1; k <= 10; k++) begin
          total++;
          if (obs_tr[d][k] !== exp_tr[d][k]) begin
            bad++;
            $display("FAIL rand%0d d%0d cycle%0d ctrl got=%h expected=%h", i, d, k, obs_tr[d][k], exp_tr[d][k]);
          end
        end
        total++;
        if (obs_taken[d] !== exp_taken[d] || obs_ill[d] !== exp_ill[d]) begin
          bad++;
          $display("FAIL rand%0d_flags d%0d taken=%b illegal=%b expected %b %b", i, d,
                   obs_taken[d], obs_ill[d], exp_taken[d], exp_ill[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_not_taken();
    test_taken_brzr();
    test_clr_midway();
    test_width16();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
